// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// Module      : multicycle_controller
// Description : Five-state multicycle RV32I-subset control FSM with Moore
//               outputs decoded from the latched instruction register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_LT  = 4'b0100;
    localparam logic [3:0] ALUOP_XOR = 4'b0101;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;

    localparam logic [6:0]  OPC_R    = 7'b0110011;
    localparam logic [6:0]  OPC_I    = 7'b0010011;
    localparam logic [6:0]  OPC_LW   = 7'b0000011;
    localparam logic [6:0]  OPC_SW   = 7'b0100011;
    localparam logic [6:0]  OPC_BEQ  = 7'b1100011;
    localparam logic [31:0] IR_NOP   = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        br_zero_q, br_zero_d;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;
    logic        w_alu_valid;
    logic [3:0]  w_alu_code;
    logic        w_legal;
    logic [3:0]  w_dec_op;
    logic        w_dec_src;
    logic        w_is_lw, w_is_sw, w_is_beq, w_writes_rd;

    assign w_opcode = ir_q[6:0];
    assign w_funct3 = ir_q[14:12];
    assign w_alt    = ir_q[30];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            ir_q      <= IR_NOP;
            br_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            br_zero_q <= br_zero_d;
        end
    end

    always_comb begin
        state_d   = S_IF;
        ir_d      = ir_q;
        br_zero_d = br_zero_q;
        case (state_q)
            S_IF:  begin state_d = S_ID;  ir_d = instr;      end
            S_ID:        state_d = S_EX;
            S_EX:  begin state_d = S_MEM; br_zero_d = zero;  end
            S_MEM:       state_d = S_WB;
            S_WB:        state_d = S_IF;
            default:     state_d = S_IF;
        endcase
    end

    // Shared funct3 table for R-type and I-ALU; the SUB alternate is R-type only.
    always_comb begin
        w_alu_valid = 1'b1;
        w_alu_code  = ALUOP_ADD;
        case (w_funct3)
            3'b000: w_alu_code = (w_alt && (w_opcode == OPC_R)) ? ALUOP_SUB : ALUOP_ADD;
            3'b111: w_alu_code = ALUOP_AND;
            3'b110: w_alu_code = ALUOP_OR;
            3'b100: w_alu_code = ALUOP_XOR;
            3'b010: w_alu_code = ALUOP_LT;
            3'b001: w_alu_code = ALUOP_SLL;
            3'b101: w_alu_code = w_alt ? ALUOP_SRA : ALUOP_SRL;
            default: w_alu_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_legal     = 1'b0;
        w_dec_op    = ALUOP_ADD;
        w_dec_src   = 1'b0;
        w_is_lw     = 1'b0;
        w_is_sw     = 1'b0;
        w_is_beq    = 1'b0;
        w_writes_rd = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_legal     = w_alu_valid;
                w_dec_op    = w_alu_code;
                w_writes_rd = w_alu_valid;
            end
            OPC_I: begin
                w_legal     = w_alu_valid;
                w_dec_op    = w_alu_code;
                w_dec_src   = 1'b1;
                w_writes_rd = w_alu_valid;
            end
            OPC_LW: begin
                w_legal     = (w_funct3 == 3'b010);
                w_dec_src   = 1'b1;
                w_is_lw     = w_legal;
                w_writes_rd = w_legal;
            end
            OPC_SW: begin
                w_legal   = (w_funct3 == 3'b010);
                w_dec_src = 1'b1;
                w_is_sw   = w_legal;
            end
            OPC_BEQ: begin
                w_legal  = (w_funct3 == 3'b000);
                w_dec_op = ALUOP_SUB;
                w_is_beq = w_legal;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Outputs depend only on state_q and ir_q/br_zero_q, so reset clears them at once.
    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        illegal    = (state_q != S_IF) && !w_legal;
        state      = state_q;
        case (state_q)
            S_EX: begin
                if (w_legal) begin
                    alu_op  = w_dec_op;
                    alu_src = w_dec_src;
                end
            end
            S_MEM: begin
                mem_read  = w_is_lw;
                mem_write = w_is_sw;
            end
            S_WB: begin
                reg_write  = w_writes_rd;
                mem_to_reg = w_is_lw;
                pc_write   = 1'b1;
                pc_src     = w_is_beq && br_zero_q;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_controller
// Description : Self-checking bench: vector table, corner sequences and random
//               instructions compared against a behavioural decode model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110, C_LT  = 4'b0100, C_XOR = 4'b0101;
    localparam logic [3:0] C_SRL = 4'b1000, C_SLL = 4'b1001, C_SRA = 4'b1010;
    localparam logic [3:0] C_BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic        pc_write, pc_src, illegal;
    logic [2:0]  state;
    logic [14:0] act;
    logic [14:0] act_ex, act_wb;

    int total = 0;
    int bad   = 0;

    logic [3:0] op_tab [8];

    typedef struct {
        logic [31:0] w;
        logic        zex;
        logic        zoth;
        logic [14:0] ex;
        logic [14:0] wb;
    } vec_t;
    vec_t tab [12];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, illegal, pc_src, pc_write, mem_to_reg, reg_write,
                  mem_write, mem_read, alu_src, alu_op};

    function automatic logic [14:0] pk(input int st, input bit ill, pcs, pcw,
                                       m2r, rw, mw, mr, src, input logic [3:0] op);
        logic [2:0] s3;
        s3 = st[2:0];
        return {s3, ill, pcs, pcw, m2r, rw, mw, mr, src, op};
    endfunction

    task automatic chk(input string nm, input logic [14:0] a, input logic [14:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Instruction class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 unsupported.
    function automatic void ref_decode(input logic [31:0] w, output logic legal,
                                       output logic [3:0] op, output logic src,
                                       output int cls);
        logic [2:0] f3;
        f3    = w[14:12];
        op    = C_ADD;
        src   = 1'b0;
        cls   = 5;
        legal = 1'b0;
        case (w[6:0])
            7'h33: begin
                op = op_tab[f3];
                if (w[30] && f3 == 3'd0) op = C_SUB;
                if (w[30] && f3 == 3'd5) op = C_SRA;
                cls = 0;
            end
            7'h13: begin
                op = op_tab[f3];
                if (w[30] && f3 == 3'd5) op = C_SRA;
                src = 1'b1;
                cls = 1;
            end
            7'h03: begin cls = (f3 == 3'd2) ? 2 : 5; src = 1'b1; end
            7'h23: begin cls = (f3 == 3'd2) ? 3 : 5; src = 1'b1; end
            7'h63: begin cls = (f3 == 3'd0) ? 4 : 5; op = C_SUB; end
            default: cls = 5;
        endcase
        if (op == C_BAD) cls = 5;
        legal = (cls != 5);
        if (!legal) begin op = C_ADD; src = 1'b0; end
    endfunction

    function automatic logic [14:0] model(input int k, input logic legal,
                                          input logic [3:0] op, input logic src,
                                          input int cls, input logic zex);
        return pk(k, !legal && k != 0, k == 4 && cls == 4 && zex, k == 4,
                  k == 4 && cls == 2, k == 4 && cls <= 2, k == 3 && cls == 3,
                  k == 3 && cls == 2, k == 2 && src, (k == 2) ? op : C_ADD);
    endfunction

    // Called with the next falling edge landing in S_IF; junk instr outside S_IF.
    task automatic run_instr(input logic [31:0] w, input logic zex,
                             input logic zoth, input string tag);
        logic legal, src;
        logic [3:0] op;
        int cls;
        ref_decode(w, legal, op, src, cls);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            instr = (k == 0) ? w : $urandom;
            zero  = (k == 2) ? zex : zoth;
            #1;
            chk($sformatf("%s_k%0d", tag, k), act, model(k, legal, op, src, cls, zex));
            if (k == 2) act_ex = act;
            if (k == 4) act_wb = act;
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  opcs [6];
        int          sel;

        op_tab[0] = C_ADD; op_tab[1] = C_SLL; op_tab[2] = C_LT;  op_tab[3] = C_BAD;
        op_tab[4] = C_XOR; op_tab[5] = C_SRL; op_tab[6] = C_OR;  op_tab[7] = C_AND;

        tab[0]  = '{32'h002081B3, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,0,0,C_ADD), pk(4,0,0,1,0,1,0,0,0,C_ADD)};
        tab[1]  = '{32'h402081B3, 1'b1, 1'b0, pk(2,0,0,0,0,0,0,0,0,C_SUB), pk(4,0,0,1,0,1,0,0,0,C_ADD)};
        tab[2]  = '{32'h40325213, 1'b0, 1'b1, pk(2,0,0,0,0,0,0,0,1,C_SRA), pk(4,0,0,1,0,1,0,0,0,C_ADD)};
        tab[3]  = '{32'h0080A283, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,0,1,C_ADD), pk(4,0,0,1,1,1,0,0,0,C_ADD)};
        tab[4]  = '{32'h0050A623, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,0,1,C_ADD), pk(4,0,0,1,0,0,0,0,0,C_ADD)};
        tab[5]  = '{32'h00208463, 1'b1, 1'b0, pk(2,0,0,0,0,0,0,0,0,C_SUB), pk(4,0,1,1,0,0,0,0,0,C_ADD)};
        tab[6]  = '{32'h00208463, 1'b0, 1'b1, pk(2,0,0,0,0,0,0,0,0,C_SUB), pk(4,0,0,1,0,0,0,0,0,C_ADD)};
        tab[7]  = '{32'hFFFFFFFF, 1'b1, 1'b1, pk(2,1,0,0,0,0,0,0,0,C_ADD), pk(4,1,0,1,0,0,0,0,0,C_ADD)};
        tab[8]  = '{32'h0020B1B3, 1'b0, 1'b0, pk(2,1,0,0,0,0,0,0,0,C_ADD), pk(4,1,0,1,0,0,0,0,0,C_ADD)};
        tab[9]  = '{32'h0080B283, 1'b0, 1'b0, pk(2,1,0,0,0,0,0,0,0,C_ADD), pk(4,1,0,1,0,0,0,0,0,C_ADD)};
        tab[10] = '{32'h40008093, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,0,1,C_ADD), pk(4,0,0,1,0,1,0,0,0,C_ADD)};
        tab[11] = '{32'h0020C1B3, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,0,0,C_XOR), pk(4,0,0,1,0,1,0,0,0,C_ADD)};

        #1 rst = 1'b1;
        #1 chk("reset_async", act, pk(0,0,0,0,0,0,0,0,0,C_ADD));
        @(posedge clk); #1;
        chk("reset_held", act, pk(0,0,0,0,0,0,0,0,0,C_ADD));
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_instr(tab[i].w, tab[i].zex, tab[i].zoth, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ex", i), act_ex, tab[i].ex);
            chk($sformatf("vec%0d_wb", i), act_wb, tab[i].wb);
        end

        // Asynchronous reset in S_MEM of a load.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            instr = (k == 0) ? 32'h0080A283 : 32'h0;
            zero  = 1'b0;
        end
        #1 chk("lw_mem_pre_rst", act, pk(3,0,0,0,0,0,0,1,0,C_ADD));
        rst = 1'b1;
        #1 chk("rst_in_mem", act, pk(0,0,0,0,0,0,0,0,0,C_ADD));
        @(posedge clk); #1;
        chk("rst_in_mem_held", act, pk(0,0,0,0,0,0,0,0,0,C_ADD));
        #1 rst = 1'b0;
        run_instr(32'h002081B3, 1'b0, 1'b0, "post_rst_add");
        chk("post_rst_wb", act_wb, pk(4,0,0,1,0,1,0,0,0,C_ADD));

        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
        opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'h7F;
        for (int n = 0; n < 150; n++) begin
            w   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 5) begin
                if ($urandom_range(0, 1) == 1) w[6:0] = opcs[5];
            end else begin
                w[6:0] = opcs[sel];
                if (sel >= 2 && $urandom_range(0, 3) != 0)
                    w[14:12] = (sel == 4) ? 3'd0 : 3'd2;
            end
            run_instr(w, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
